// File: rtl/serial_sub8.sv
// Bit-serial WIDTH-bit subtract sequencer: drives one external sub1bit cell LSB first,
// chains the borrow through a local register. Optional macro SERIAL_SUB_OVF_EN adds ovf.
module serial_sub8 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_bin,
  input  logic             ser_d,
  input  logic             ser_bout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-2:0] d_sr;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] diff_final;
  logic             in_shift;
  logic             accept;
  logic             last_bit;

  assign in_shift   = (state == SHIFT);
  assign accept     = (state == IDLE) && start;
  assign last_bit   = in_shift && (cnt == CNT_LAST);
  assign diff_final = {ser_d, d_sr};

  // Serial cell inputs come only from registers, gated off outside SHIFT
  assign ser_a   = in_shift & a_sr[0];
  assign ser_b   = in_shift & b_sr[0];
  assign ser_bin = in_shift & brw;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      ready <= (state_next == IDLE);
      busy  <= (state_next == SHIFT) || (state_next == DONE);
      done  <= (state_next == DONE);
    end
  end

  // Operand load, serial shift and borrow chaining
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      d_sr <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
    end else if (in_shift) begin
      a_sr          <= a_sr >> 1;
      b_sr          <= b_sr >> 1;
      d_sr          <= d_sr >> 1;
      d_sr[WIDTH-2] <= ser_d;
      brw           <= ser_bout;
      if (!last_bit) cnt <= cnt + CNT_W'(1);
    end
  end

  // Result registers, updated only on the edge that captures the MSB
  always_ff @(posedge clk) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
      zero <= 1'b0;
    end else if (last_bit) begin
      diff <= diff_final;
      bout <= ser_bout;
      zero <= (diff_final == '0);
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic sa, sb;

  // Signed overflow: operand signs differ and result sign differs from minuend
  always_ff @(posedge clk) begin
    if (rst) begin
      sa  <= 1'b0;
      sb  <= 1'b0;
      ovf <= 1'b0;
    end else begin
      if (accept) begin
        sa <= a[WIDTH-1];
        sb <= b[WIDTH-1];
      end
      if (last_bit) ovf <= (sa ^ sb) & (sa ^ ser_d);
    end
  end
`endif

endmodule

// File: tb/tb_serial_sub8.sv
// Directed self-checking bench for serial_sub8 with a behavioural sub1bit cell.
module tb_serial_sub8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       ready, busy, done, bout, zero;
  logic [7:0] diff;
  logic       ovf;
  logic       ser_a, ser_b, ser_bin, ser_d, ser_bout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // External full-subtractor cell
  assign ser_d    = ser_a ^ ser_b ^ ser_bin;
  assign ser_bout = (~ser_a & ser_b) | (~(ser_a ^ ser_b) & ser_bin);

`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  serial_sub8 #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done),
    .diff(diff), .bout(bout), .zero(zero),
`ifdef SERIAL_SUB_OVF_EN
    .ovf(ovf),
`endif
    .ser_a(ser_a), .ser_b(ser_b), .ser_bin(ser_bin),
    .ser_d(ser_d), .ser_bout(ser_bout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One subtraction; inj >= 0 pulses an ignored start (0xFF-0x00) in that SHIFT cycle
  task automatic run_sub(input logic [7:0] ta, input logic [7:0] tb,
                         input logic [7:0] ediff, input logic ebout,
                         input logic ezero, input logic eovf, input int inj);
    logic brw_exp;
    logic [7:0] ka, kb;
    ka = ta;
    kb = tb;
    check("ready_before", 32'(ready), 32'd1);
    a = ta; b = tb; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'h00; b = 8'h00;
    brw_exp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("busy_shift", 32'(busy), 32'd1);
      check("ready_shift", 32'(ready), 32'd0);
      check("done_shift", 32'(done), 32'd0);
      check("ser_a", 32'(ser_a), 32'(ka[i]));
      check("ser_b", 32'(ser_b), 32'(kb[i]));
      check("ser_bin", 32'(ser_bin), 32'(brw_exp));
      brw_exp = (~ka[i] & kb[i]) | (~(ka[i] ^ kb[i]) & brw_exp);
      if (i == inj) begin
        a = 8'hFF; b = 8'h00; start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    check("done_pulse", 32'(done), 32'd1);
    check("busy_done", 32'(busy), 32'd1);
    check("diff", 32'(diff), 32'(ediff));
    check("bout", 32'(bout), 32'(ebout));
    check("zero", 32'(zero), 32'(ezero));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", 32'(ovf), 32'(eovf));
`else
    if (eovf === 1'bx) check("ovf_arg", 32'd0, 32'd1);
`endif
    check("ser_bin_done", 32'(ser_bin), 32'd0);
    tick();
    check("done_off", 32'(done), 32'd0);
    check("ready_after", 32'(ready), 32'd1);
    check("busy_after", 32'(busy), 32'd0);
    tick();
    check("done_single", 32'(done), 32'd0);
    check("diff_held", 32'(diff), 32'(ediff));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ser", 32'({ser_a, ser_b, ser_bin}), 32'd0);

    run_sub(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 1'b0, -1);
    run_sub(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, -1);
    run_sub(8'h37, 8'h37, 8'h00, 1'b0, 1'b1, 1'b0, -1);
    run_sub(8'h12, 8'h05, 8'h0D, 1'b0, 1'b0, 1'b0, 3);

    // Reset during the 5th SHIFT cycle
    a = 8'h5A; b = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_diff", 32'(diff), 32'd0);
    check("mid_rst_bout", 32'(bout), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_done_after_rst", 32'(done), 32'd0);
    end
    run_sub(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0, -1);

    run_sub(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, -1);
    run_sub(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1, -1);
    run_sub(8'hC3, 8'h42, 8'h81, 1'b0, 1'b0, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
